// File: rtl/fft_pkg.sv
// Shared definitions for the radix-4 FFT datapath: TYPE strings, group count and
// the butterfly output width rule that the twiddle multiplier also relies on.
package fft_pkg;
    localparam string TYPE_FORWARD = "forvard";
    localparam string TYPE_INVERSE = "invers";

    function automatic int r4_groups(input int size_data_fi);
        return (1 << size_data_fi) / 4;
    endfunction

    function automatic int r4_out_width(input int data_width);
        return data_width + 2;
    endfunction
endpackage

// File: rtl/fft_cplx_addsub.sv
// Registered complex add/subtract pair: sum = a+b and dif = a-b, one bit wider than
// the inputs so nothing can overflow. Loads only when en is high, otherwise holds.
module fft_cplx_addsub #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] a_q,
    input  logic signed [W-1:0] b_i,
    input  logic signed [W-1:0] b_q,
    output logic signed [W:0]   sum_i,
    output logic signed [W:0]   sum_q,
    output logic signed [W:0]   dif_i,
    output logic signed [W:0]   dif_q
);
    logic signed [W:0] sum_i_d, sum_i_q;
    logic signed [W:0] sum_q_d, sum_q_q;
    logic signed [W:0] dif_i_d, dif_i_q;
    logic signed [W:0] dif_q_d, dif_q_q;

    always_comb begin
        sum_i_d = sum_i_q;
        sum_q_d = sum_q_q;
        dif_i_d = dif_i_q;
        dif_q_d = dif_q_q;
        if (en) begin
            sum_i_d = {a_i[W-1], a_i} + {b_i[W-1], b_i};
            sum_q_d = {a_q[W-1], a_q} + {b_q[W-1], b_q};
            dif_i_d = {a_i[W-1], a_i} - {b_i[W-1], b_i};
            dif_q_d = {a_q[W-1], a_q} - {b_q[W-1], b_q};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_i_q <= '0;
            sum_q_q <= '0;
            dif_i_q <= '0;
            dif_q_q <= '0;
        end else begin
            sum_i_q <= sum_i_d;
            sum_q_q <= sum_q_d;
            dif_i_q <= dif_i_d;
            dif_q_q <= dif_q_d;
        end
    end

    assign sum_i = sum_i_q;
    assign sum_q = sum_q_q;
    assign dif_i = dif_i_q;
    assign dif_q = dif_q_q;
endmodule

// File: rtl/fft_r4_butterfly.sv
// Radix-4 DIF butterfly: gathers four serial complex samples, computes the 4-point
// DFT in two registered add/sub stages and tags each result with its group index.
module fft_r4_butterfly
    import fft_pkg::*;
#(
    parameter int    SIZE_DATA_FI  = 4,
    parameter int    DATA_FFT_SIZE = 16,
    parameter string TYPE          = TYPE_FORWARD,
    localparam int   OW            = r4_out_width(DATA_FFT_SIZE)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic                            in_start,
    input  logic signed [DATA_FFT_SIZE-1:0] in_data_i,
    input  logic signed [DATA_FFT_SIZE-1:0] in_data_q,
    output logic signed [OW-1:0]            out_data0_i,
    output logic signed [OW-1:0]            out_data0_q,
    output logic signed [OW-1:0]            out_data1_i,
    output logic signed [OW-1:0]            out_data1_q,
    output logic signed [OW-1:0]            out_data2_i,
    output logic signed [OW-1:0]            out_data2_q,
    output logic signed [OW-1:0]            out_data3_i,
    output logic signed [OW-1:0]            out_data3_q,
    output logic [15:0]                     fi_deg,
    output logic                            outValid
);
    localparam int W       = DATA_FFT_SIZE;
    localparam int GROUPS  = r4_groups(SIZE_DATA_FI);
    localparam int KW      = SIZE_DATA_FI - 2;
    localparam bit INVERSE = (TYPE == TYPE_INVERSE);

    logic signed [W-1:0] re_d [4], re_q [4];
    logic signed [W-1:0] im_d [4], im_q [4];
    logic [1:0]    sc_d, sc_q, slot;
    logic [KW-1:0] k_d, k_q;
    logic          grp_valid_d, grp_valid_q;
    logic [KW-1:0] grp_k_d, grp_k_q;
    logic          s1_valid_d, s1_valid_q;
    logic [KW-1:0] s1_k_d, s1_k_q;
    logic          out_valid_d, out_valid_q;
    logic [15:0]   fi_deg_d, fi_deg_q;

    // in_start always lands in slot a and restarts the group index, dropping any partial group
    always_comb begin
        re_d        = re_q;
        im_d        = im_q;
        sc_d        = sc_q;
        k_d         = k_q;
        slot        = sc_q;
        grp_valid_d = 1'b0;
        grp_k_d     = grp_k_q;
        s1_valid_d  = grp_valid_q;
        s1_k_d      = grp_valid_q ? grp_k_q : s1_k_q;
        out_valid_d = s1_valid_q;
        fi_deg_d    = s1_valid_q ? 16'(s1_k_q) : fi_deg_q;
        if (en) begin
            slot       = in_start ? 2'd0 : sc_q;
            re_d[slot] = in_data_i;
            im_d[slot] = in_data_q;
            sc_d       = slot + 2'd1;
            if (in_start) begin
                k_d = '0;
            end else if (sc_q == 2'd3) begin
                grp_valid_d = 1'b1;
                grp_k_d     = k_q;
                k_d         = (k_q == KW'(GROUPS - 1)) ? '0 : k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            re_q        <= '{default: '0};
            im_q        <= '{default: '0};
            sc_q        <= '0;
            k_q         <= '0;
            grp_valid_q <= 1'b0;
            grp_k_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_k_q      <= '0;
            out_valid_q <= 1'b0;
            fi_deg_q    <= '0;
        end else begin
            re_q        <= re_d;
            im_q        <= im_d;
            sc_q        <= sc_d;
            k_q         <= k_d;
            grp_valid_q <= grp_valid_d;
            grp_k_q     <= grp_k_d;
            s1_valid_q  <= s1_valid_d;
            s1_k_q      <= s1_k_d;
            out_valid_q <= out_valid_d;
            fi_deg_q    <= fi_deg_d;
        end
    end

    logic signed [W:0] p_i, p_q, m_i, m_q, s_i, s_q, t_i, t_q, neg_t_i;

    fft_cplx_addsub #(.W(W)) u_s1_ac (
        .clk(clk), .reset(reset), .en(grp_valid_q),
        .a_i(re_q[0]), .a_q(im_q[0]), .b_i(re_q[2]), .b_q(im_q[2]),
        .sum_i(p_i), .sum_q(p_q), .dif_i(m_i), .dif_q(m_q)
    );

    fft_cplx_addsub #(.W(W)) u_s1_bd (
        .clk(clk), .reset(reset), .en(grp_valid_q),
        .a_i(re_q[1]), .a_q(im_q[1]), .b_i(re_q[3]), .b_q(im_q[3]),
        .sum_i(s_i), .sum_q(s_q), .dif_i(t_i), .dif_q(t_q)
    );

    // -j*t = (t_q, -t_i); t never reaches the most negative W+1 value, so the negation is exact
    assign neg_t_i = -t_i;

    logic signed [OW-1:0] x1f_i, x1f_q, x3f_i, x3f_q;

    fft_cplx_addsub #(.W(W + 1)) u_s2_ps (
        .clk(clk), .reset(reset), .en(s1_valid_q),
        .a_i(p_i), .a_q(p_q), .b_i(s_i), .b_q(s_q),
        .sum_i(out_data0_i), .sum_q(out_data0_q), .dif_i(out_data2_i), .dif_q(out_data2_q)
    );

    fft_cplx_addsub #(.W(W + 1)) u_s2_mt (
        .clk(clk), .reset(reset), .en(s1_valid_q),
        .a_i(m_i), .a_q(m_q), .b_i(t_q), .b_q(neg_t_i),
        .sum_i(x1f_i), .sum_q(x1f_q), .dif_i(x3f_i), .dif_q(x3f_q)
    );

    assign out_data1_i = INVERSE ? x3f_i : x1f_i;
    assign out_data1_q = INVERSE ? x3f_q : x1f_q;
    assign out_data3_i = INVERSE ? x1f_i : x3f_i;
    assign out_data3_q = INVERSE ? x1f_q : x3f_q;
    assign fi_deg      = fi_deg_q;
    assign outValid    = out_valid_q;
endmodule

// File: tb/tb_fft_r4_butterfly.sv
// Bench for fft_r4_butterfly: forward and inverse instances share one stimulus stream and
// are compared against a direct 4-point DFT model computed from the collected samples.
module tb_fft_r4_butterfly;
    localparam int SIZE_FI = 4;
    localparam int W       = 16;
    localparam int OW      = W + 2;
    localparam int GROUPS  = (1 << SIZE_FI) / 4;
    localparam int VW      = 8 * OW;

    typedef struct {
        logic [VW-1:0] fwd;
        logic [VW-1:0] inv;
        logic [15:0]   k;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic in_start = 1'b0;
    logic signed [W-1:0] in_i = '0;
    logic signed [W-1:0] in_q = '0;
    logic signed [OW-1:0] f0i, f0q, f1i, f1q, f2i, f2q, f3i, f3q;
    logic signed [OW-1:0] v0i, v0q, v1i, v1q, v2i, v2q, v3i, v3q;
    logic [15:0] fi_deg, fi_deg_inv;
    logic outValid, outValid_inv;
    logic [VW-1:0] fwd_vec, inv_vec;

    int checks = 0;
    int failures = 0;

    int   cur_i [$];
    int   cur_q [$];
    int   mk = 0;
    exp_t exp_q [$];

    assign fwd_vec = {f0i, f0q, f1i, f1q, f2i, f2q, f3i, f3q};
    assign inv_vec = {v0i, v0q, v1i, v1q, v2i, v2q, v3i, v3q};

    always #5 clk = ~clk;

    fft_r4_butterfly #(.SIZE_DATA_FI(SIZE_FI), .DATA_FFT_SIZE(W), .TYPE("forvard")) dut_fwd (
        .clk(clk), .reset(reset), .en(en), .in_start(in_start),
        .in_data_i(in_i), .in_data_q(in_q),
        .out_data0_i(f0i), .out_data0_q(f0q), .out_data1_i(f1i), .out_data1_q(f1q),
        .out_data2_i(f2i), .out_data2_q(f2q), .out_data3_i(f3i), .out_data3_q(f3q),
        .fi_deg(fi_deg), .outValid(outValid)
    );

    fft_r4_butterfly #(.SIZE_DATA_FI(SIZE_FI), .DATA_FFT_SIZE(W), .TYPE("invers")) dut_inv (
        .clk(clk), .reset(reset), .en(en), .in_start(in_start),
        .in_data_i(in_i), .in_data_q(in_q),
        .out_data0_i(v0i), .out_data0_q(v0q), .out_data1_i(v1i), .out_data1_q(v1q),
        .out_data2_i(v2i), .out_data2_q(v2q), .out_data3_i(v3i), .out_data3_q(v3q),
        .fi_deg(fi_deg_inv), .outValid(outValid_inv)
    );

    // X[k] = sum x[n] * w^(n*k) with w = -j (forward) or +j (inverse)
    function automatic logic [VW-1:0] dft_vec(input bit inv);
        logic [VW-1:0] v;
        int sr, si, e;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            sr = 0;
            si = 0;
            for (int n = 0; n < 4; n++) begin
                e = (n * k) % 4;
                if (inv) e = (4 - e) % 4;
                case (e)
                    0: begin sr += cur_i[n]; si += cur_q[n]; end
                    1: begin sr += cur_q[n]; si -= cur_i[n]; end
                    2: begin sr -= cur_i[n]; si -= cur_q[n]; end
                    default: begin sr -= cur_q[n]; si += cur_i[n]; end
                endcase
            end
            v[VW-1-2*OW*k -: 2*OW] = {OW'(sr), OW'(si)};
        end
        return v;
    endfunction

    function automatic int rnd();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    task automatic model_reset();
        cur_i.delete();
        cur_q.delete();
        exp_q.delete();
        mk = 0;
    endtask

    task automatic model_accept(input bit st, input int di, input int dq);
        exp_t e;
        if (st) begin
            cur_i.delete();
            cur_q.delete();
            mk = 0;
        end
        cur_i.push_back(di);
        cur_q.push_back(dq);
        if (cur_i.size() == 4) begin
            e.fwd = dft_vec(1'b0);
            e.inv = dft_vec(1'b1);
            e.k   = 16'(mk);
            exp_q.push_back(e);
            cur_i.delete();
            cur_q.delete();
            mk = (mk + 1) % GROUPS;
        end
    endtask

    task automatic send(input bit st, input int di, input int dq);
        en       = 1'b1;
        in_start = st;
        in_i     = 16'(di);
        in_q     = 16'(dq);
        model_accept(st, di, dq);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit st);
        en       = 1'b0;
        in_start = st;
        repeat (n) @(negedge clk);
        in_start = 1'b0;
    endtask

    task automatic send_group(input bit st, input int gi[4], input int gq[4], input int gap);
        for (int n = 0; n < 4; n++) begin
            send(st && (n == 0), gi[n], gq[n]);
            if (n < 3 && gap > 0) idle(gap, 1'b1);
        end
        idle(0, 1'b0);
    endtask

    task automatic watch(input int n, output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            if (outValid === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (exp_q.size() > 0);
        if (ok) e = exp_q.pop_front();
        else begin
            e.fwd = '0;
            e.inv = '0;
            e.k   = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b0;
        in_start = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", outValid); end
        checks++;
        if (fwd_vec !== '0) begin failures++; $display("[TB] FAIL reset_fwd got=%h want=0", fwd_vec); end
        checks++;
        if (inv_vec !== '0) begin failures++; $display("[TB] FAIL reset_inv got=%h want=0", inv_vec); end
        checks++;
        if (fi_deg !== 16'd0) begin failures++; $display("[TB] FAIL reset_fideg got=%0d want=0", fi_deg); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_impulse();
        int gi[4] = '{100, 0, 0, 0};
        int gq[4] = '{0, 0, 0, 0};
        logic [VW-1:0] want;
        int cnt, first;
        exp_t e;
        bit ok;
        want = {4{18'd100, 18'd0}};
        send_group(1'b1, gi, gq, 0);
        watch(6, cnt, first);
        pop_exp(e, ok);
        checks++;
        if (cnt != 1) begin failures++; $display("[TB] FAIL impulse_pulses got=%0d want=1", cnt); end
        checks++;
        if (first != 2) begin failures++; $display("[TB] FAIL impulse_latency got=%0d want=2", first); end
        checks++;
        if (fwd_vec !== want) begin failures++; $display("[TB] FAIL impulse_fwd got=%h want=%h", fwd_vec, want); end
        checks++;
        if (inv_vec !== want) begin failures++; $display("[TB] FAIL impulse_inv got=%h want=%h", inv_vec, want); end
        checks++;
        if (fi_deg !== 16'd0) begin failures++; $display("[TB] FAIL impulse_fideg got=%0d want=0", fi_deg); end
        checks++;
        if (!ok || fwd_vec !== e.fwd) begin failures++; $display("[TB] FAIL impulse_model got=%h want=%h", fwd_vec, e.fwd); end
    endtask

    task automatic test_dft_patterns();
        int ti[3][4] = '{'{1, 1, 1, 1}, '{0, 1, 0, 0}, '{-32768, -32768, -32768, -32768}};
        int tq[3][4] = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{-32768, -32768, -32768, -32768}};
        logic [VW-1:0] want_f [3];
        logic [VW-1:0] want_i [3];
        int gi[4], gq[4];
        int cnt, first;
        exp_t e;
        bit ok;
        want_f[0] = {18'd4, 18'd0, {6{18'd0}}};
        want_i[0] = want_f[0];
        want_f[1] = {18'd1, 18'd0, 18'd0, 18'h3FFFF, 18'h3FFFF, 18'd0, 18'd0, 18'd1};
        want_i[1] = {18'd1, 18'd0, 18'd0, 18'd1, 18'h3FFFF, 18'd0, 18'd0, 18'h3FFFF};
        want_f[2] = {18'h20000, 18'h20000, {6{18'd0}}};
        want_i[2] = want_f[2];
        for (int c = 0; c < 3; c++) begin
            send_group(1'b1, ti[c], tq[c], 0);
            watch(6, cnt, first);
            pop_exp(e, ok);
            checks++;
            if (cnt != 1) begin failures++; $display("[TB] FAIL pattern%0d_pulses got=%0d want=1", c, cnt); end
            checks++;
            if (fwd_vec !== want_f[c]) begin failures++; $display("[TB] FAIL pattern%0d_fwd got=%h want=%h", c, fwd_vec, want_f[c]); end
            checks++;
            if (inv_vec !== want_i[c]) begin failures++; $display("[TB] FAIL pattern%0d_inv got=%h want=%h", c, inv_vec, want_i[c]); end
            checks++;
            if (fi_deg !== 16'd0) begin failures++; $display("[TB] FAIL pattern%0d_fideg got=%0d want=0", c, fi_deg); end
        end
        // random groups without in_start, so the group index also walks through its wrap
        for (int r = 0; r < 8; r++) begin
            for (int n = 0; n < 4; n++) begin
                gi[n] = rnd();
                gq[n] = rnd();
            end
            send_group(1'b0, gi, gq, int'($urandom_range(0, 2)));
            watch(6, cnt, first);
            pop_exp(e, ok);
            checks++;
            if (!ok || cnt != 1) begin failures++; $display("[TB] FAIL random%0d_pulses got=%0d want=1", r, cnt); end
            checks++;
            if (fwd_vec !== e.fwd) begin failures++; $display("[TB] FAIL random%0d_fwd got=%h want=%h", r, fwd_vec, e.fwd); end
            checks++;
            if (inv_vec !== e.inv) begin failures++; $display("[TB] FAIL random%0d_inv got=%h want=%h", r, inv_vec, e.inv); end
            checks++;
            if (fi_deg !== e.k) begin failures++; $display("[TB] FAIL random%0d_fideg got=%0d want=%0d", r, fi_deg, e.k); end
        end
    endtask

    task automatic test_back_to_back();
        int want_k[5] = '{0, 1, 2, 3, 0};
        int pulse_cyc[$];
        fork
            begin
                for (int i = 0; i < 20; i++) send(i == 0, rnd(), rnd());
                idle(0, 1'b0);
            end
            begin
                exp_t e;
                bit ok;
                int idx;
                for (int c = 0; c < 40; c++) begin
                    if (outValid === 1'b1) begin
                        idx = pulse_cyc.size();
                        pulse_cyc.push_back(c);
                        pop_exp(e, ok);
                        checks++;
                        if (!ok || fwd_vec !== e.fwd) begin failures++; $display("[TB] FAIL stream%0d_fwd got=%h want=%h", idx, fwd_vec, e.fwd); end
                        checks++;
                        if (inv_vec !== e.inv) begin failures++; $display("[TB] FAIL stream%0d_inv got=%h want=%h", idx, inv_vec, e.inv); end
                        checks++;
                        if (idx < 5 && fi_deg !== 16'(want_k[idx])) begin failures++; $display("[TB] FAIL stream%0d_fideg got=%0d want=%0d", idx, fi_deg, want_k[idx]); end
                        checks++;
                        if (outValid_inv !== 1'b1 || fi_deg_inv !== fi_deg) begin failures++; $display("[TB] FAIL stream%0d_inv_ctrl got=%b/%0d want=1/%0d", idx, outValid_inv, fi_deg_inv, fi_deg); end
                    end
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (pulse_cyc.size() != 5) begin failures++; $display("[TB] FAIL stream_pulses got=%0d want=5", pulse_cyc.size()); end
        checks++;
        if (pulse_cyc.size() == 0 || pulse_cyc[0] != 6) begin failures++; $display("[TB] FAIL stream_first got=%0d want=6", pulse_cyc.size() > 0 ? pulse_cyc[0] : -1); end
        for (int i = 1; i < pulse_cyc.size(); i++) begin
            checks++;
            if (pulse_cyc[i] - pulse_cyc[i-1] != 4) begin failures++; $display("[TB] FAIL stream_spacing%0d got=%0d want=4", i, pulse_cyc[i] - pulse_cyc[i-1]); end
        end
    endtask

    task automatic test_gaps_restart();
        int gi[4], gq[4];
        int cnt, first;
        exp_t e;
        bit ok;
        for (int n = 0; n < 4; n++) begin
            gi[n] = rnd();
            gq[n] = rnd();
        end
        // gaps carry in_start with en low, which must be ignored
        send_group(1'b1, gi, gq, 2);
        watch(6, cnt, first);
        pop_exp(e, ok);
        checks++;
        if (!ok || cnt != 1 || first != 2) begin failures++; $display("[TB] FAIL gaps_pulse got=%0d@%0d want=1@2", cnt, first); end
        checks++;
        if (fwd_vec !== e.fwd) begin failures++; $display("[TB] FAIL gaps_fwd got=%h want=%h", fwd_vec, e.fwd); end
        checks++;
        if (inv_vec !== e.inv) begin failures++; $display("[TB] FAIL gaps_inv got=%h want=%h", inv_vec, e.inv); end

        for (int s = 0; s < 2; s++) begin
            fork
                begin
                    for (int n = 0; n < 2 + s; n++) send(1'b0, rnd(), rnd());
                    for (int n = 0; n < 4; n++) send(n == 0, rnd(), rnd());
                    idle(0, 1'b0);
                end
                watch(14, cnt, first);
            join
            pop_exp(e, ok);
            checks++;
            if (!ok || cnt != 1) begin failures++; $display("[TB] FAIL restart%0d_pulses got=%0d want=1", s, cnt); end
            checks++;
            if (fwd_vec !== e.fwd) begin failures++; $display("[TB] FAIL restart%0d_fwd got=%h want=%h", s, fwd_vec, e.fwd); end
            checks++;
            if (fi_deg !== 16'd0) begin failures++; $display("[TB] FAIL restart%0d_fideg got=%0d want=0", s, fi_deg); end
        end
    endtask

    task automatic test_reset_mid();
        int gi[4], gq[4];
        int cnt, first;
        exp_t e;
        bit ok;
        for (int n = 0; n < 4; n++) begin
            gi[n] = rnd();
            gq[n] = rnd();
        end
        send_group(1'b1, gi, gq, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        watch(6, cnt, first);
        checks++;
        if (cnt != 0) begin failures++; $display("[TB] FAIL midreset_pulses got=%0d want=0", cnt); end
        checks++;
        if (fwd_vec !== '0 || inv_vec !== '0) begin failures++; $display("[TB] FAIL midreset_data got=%h want=0", fwd_vec | inv_vec); end
        checks++;
        if (fi_deg !== 16'd0) begin failures++; $display("[TB] FAIL midreset_fideg got=%0d want=0", fi_deg); end
        for (int n = 0; n < 4; n++) begin
            gi[n] = rnd();
            gq[n] = rnd();
        end
        send_group(1'b0, gi, gq, 0);
        watch(6, cnt, first);
        pop_exp(e, ok);
        checks++;
        if (!ok || cnt != 1) begin failures++; $display("[TB] FAIL resume_pulses got=%0d want=1", cnt); end
        checks++;
        if (fwd_vec !== e.fwd) begin failures++; $display("[TB] FAIL resume_fwd got=%h want=%h", fwd_vec, e.fwd); end
        checks++;
        if (fi_deg !== 16'd0) begin failures++; $display("[TB] FAIL resume_fideg got=%0d want=0", fi_deg); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dft_patterns();
        test_back_to_back();
        test_gaps_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
